// File: rtl/tlb_cmd_if.sv
// TLB command/response channel between CP0/pipeline (master) and tlb_manager (slave).
// Commands use a valid/ready handshake. Responses are a one-cycle pulse with no back-pressure.
interface tlb_cmd_if #(
  parameter int IDX_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IDX_W-1:0] cmd_index;
  logic [77:0]      cmd_entry;
  logic             resp_valid;
  logic [1:0]       resp_op;
  logic [IDX_W-1:0] resp_index;
  logic [77:0]      resp_entry;
  logic             resp_miss;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_entry,
    input  cmd_ready, resp_valid, resp_op, resp_index, resp_entry, resp_miss
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_entry,
    output cmd_ready, resp_valid, resp_op, resp_index, resp_entry, resp_miss
  );
endinterface

// File: rtl/tlb_manager.sv
// tlb_manager: the only writer of the TLB entry array.
// It executes the TLBR, TLBWI, TLBWR and TLBP instructions and maintains the CP0 Random counter.
// Each entry is 78 bits: {vpn2[18:0], asid[7:0], G, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1}.
// Build option TLB_PROBE_PARALLEL_EN: TLBP compares every entry in the accept cycle.
// When that option is not defined, TLBP scans one entry per cycle.
module tlb_manager #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  tlb_cmd_if.slave                 bus,
  input  logic [IDX_W-1:0]         wired_i,
  input  logic                     wired_we,
  output logic [IDX_W-1:0]         random_o,
  output logic [78*TLB_ENTRIES-1:0] entries_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(TLB_ENTRIES - 1);

  logic [77:0]      entries [TLB_ENTRIES];
  logic [0:0]       state;
  logic [IDX_W-1:0] random_q;
  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [18:0]      cmd_vpn2;
  logic [7:0]       cmd_asid;

  // A match requires an equal VPN2, and either the global bit or an equal ASID.
  function automatic logic entry_match(input logic [77:0] e, input logic [18:0] vpn2,
                                       input logic [7:0] asid);
    return (e[77:59] == vpn2) && (e[50] || (e[58:51] == asid));
  endfunction

  assign bus.cmd_ready = (state == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign cmd_vpn2      = bus.cmd_entry[77:59];
  assign cmd_asid      = bus.cmd_entry[58:51];
  assign random_o      = random_q;

  // Write decode: TLBWR takes its slot from the current Random value.
  always_comb begin
    wr_en  = accept && ((bus.cmd_op == OP_TLBWI) || (bus.cmd_op == OP_TLBWR));
    wr_idx = (bus.cmd_op == OP_TLBWR) ? random_q : bus.cmd_index;
  end

  // Entry array storage. The lookup logic observes it directly, so it must start from a known state.
  // NOTE: reset every element explicitly. An unreset array would expose X to the lookup logic after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_idx] <= bus.cmd_entry;
    end
  end

  for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_flat
    assign entries_o[78*g +: 78] = entries[g];
  end

  // Random counter. Wired writes take priority, then the wrap at or below Wired, then the decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    random_q <= TOP_IDX;
    else if (wired_we)          random_q <= TOP_IDX;
    else if (random_q <= wired_i) random_q <= TOP_IDX;
    else                        random_q <= random_q - 1'b1;
  end

`ifdef TLB_PROBE_PARALLEL_EN
  logic             par_hit;
  logic [IDX_W-1:0] par_idx;

  // Parallel probe. The loop walks from the highest index down, so the lowest matching index is assigned last and wins.
  // NOTE: defaults come first so that every path assigns both outputs, which keeps this logic free of latches.
  always_comb begin
    par_hit = 1'b0;
    par_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (entry_match(entries[i], cmd_vpn2, cmd_asid)) begin
        par_hit = 1'b1;
        par_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] scan_idx;
  logic [18:0]      key_vpn2;
  logic [7:0]       key_asid;
`endif

  // Command FSM and registered response. resp_valid is a single-cycle pulse; the other fields hold their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_clear();
`ifndef TLB_PROBE_PARALLEL_EN
      scan_idx   <= '0;
      key_vpn2   <= '0;
      key_asid   <= '0;
`endif
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.cmd_op)
              OP_TLBR: begin
                bus.resp_valid <= 1'b1;
                bus.resp_op    <= OP_TLBR;
                bus.resp_index <= bus.cmd_index;
                bus.resp_entry <= entries[bus.cmd_index];
                bus.resp_miss  <= 1'b0;
              end
              OP_TLBWI, OP_TLBWR: begin
                bus.resp_valid <= 1'b1;
                bus.resp_op    <= bus.cmd_op;
                bus.resp_index <= wr_idx;
                bus.resp_entry <= '0;
                bus.resp_miss  <= 1'b0;
              end
              default: begin
`ifdef TLB_PROBE_PARALLEL_EN
                bus.resp_valid <= 1'b1;
                bus.resp_op    <= OP_TLBP;
                bus.resp_index <= par_hit ? par_idx : '0;
                bus.resp_entry <= '0;
                bus.resp_miss  <= !par_hit;
`else
                key_vpn2 <= cmd_vpn2;
                key_asid <= cmd_asid;
                scan_idx <= '0;
                state    <= SCAN;
`endif
              end
            endcase
          end
        end
`ifndef TLB_PROBE_PARALLEL_EN
        SCAN: begin
          if (entry_match(entries[scan_idx], key_vpn2, key_asid)) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b1;
            bus.resp_op    <= OP_TLBP;
            bus.resp_index <= scan_idx;
            bus.resp_entry <= '0;
            bus.resp_miss  <= 1'b0;
          end else if (scan_idx == TOP_IDX) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b1;
            bus.resp_op    <= OP_TLBP;
            bus.resp_index <= '0;
            bus.resp_entry <= '0;
            bus.resp_miss  <= 1'b1;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Reset values for the response register fields.
  task automatic resp_clear();
    bus.resp_valid <= 1'b0;
    bus.resp_op    <= '0;
    bus.resp_index <= '0;
    bus.resp_entry <= '0;
    bus.resp_miss  <= 1'b0;
  endtask

endmodule

// File: tb/tb_tlb_manager.sv
// Testbench for tlb_manager. Directed steps are followed by a randomized phase.
// Every result is compared with a behavioural model of the entry array and the Random counter.
module tb_tlb_manager;
  localparam int N  = 16;
  localparam int IW = 4;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_WI = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_P  = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [IW-1:0]     wired_i;
  logic              wired_we;
  logic [IW-1:0]     random_o;
  logic [78*N-1:0]   entries_o;

  tlb_cmd_if #(.IDX_W(IW)) bus ();

  tlb_manager #(.TLB_ENTRIES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .wired_i   (wired_i),
    .wired_we  (wired_we),
    .random_o  (random_o),
    .entries_o (entries_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [77:0] m_ent [N];
  int          m_rand;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [77:0] slot(input int i);
    return entries_o[78*i +: 78];
  endfunction

  function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                      input logic g, input logic [19:0] pfn0, input logic v0);
    return {vpn2, asid, g, pfn0, 3'b0, 1'b0, v0, 20'b0, 3'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [77:0] rnd_entry();
    logic [18:0] v;
    logic [7:0]  a;
    logic        g;
    v = 19'h00100 + 19'($urandom_range(0, 3));
    a = 8'($urandom_range(0, 3));
    g = ($urandom_range(0, 3) == 0);
    return {v, a, g, 20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom)};
  endfunction

  // Advances one clock edge and the Random model with it, then samples random_o 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst)                  m_rand = N - 1;
    else if (wired_we)        m_rand = N - 1;
    else if (m_rand <= int'(wired_i)) m_rand = N - 1;
    else                      m_rand = m_rand - 1;
    #1;
    check("random", random_o, m_rand);
  endtask

  // TLBR, TLBWI or TLBWR, accepted in the current cycle. The response is checked one cycle later.
  task automatic do_rw(input logic [1:0] op, input int idx, input logic [77:0] e);
    int          widx;
    logic [77:0] exp_e;
    widx  = (op == OP_WR) ? m_rand : idx;
    exp_e = (op == OP_R) ? m_ent[idx] : '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_index = IW'(idx);
    bus.cmd_entry = e;
    check("rw_ready", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    if (op != OP_R) m_ent[widx] = e;
    check("rw_resp_valid", bus.resp_valid, 1'b1);
    check("rw_resp_op", bus.resp_op, op);
    check("rw_resp_index", bus.resp_index, widx);
    check("rw_resp_entry", bus.resp_entry, exp_e);
    if (op != OP_R) check("rw_slot", slot(widx), e);
  endtask

  // TLBP. With hold set, cmd_valid stays high with a TLBR of index 0 queued behind the probe.
  task automatic do_probe(input logic [18:0] vpn2, input logic [7:0] asid, input logic hold,
                          output int got_idx);
    int          exp_idx;
    int          lat;
    int          cnt;
    logic [77:0] exp_r;
    exp_idx = -1;
    for (int i = 0; i < N; i++)
      if (exp_idx < 0 && m_ent[i][77:59] == vpn2 && (m_ent[i][50] || m_ent[i][58:51] == asid))
        exp_idx = i;
`ifdef TLB_PROBE_PARALLEL_EN
    lat = 1;
`else
    lat = (exp_idx < 0) ? N + 1 : exp_idx + 2;
`endif
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_P;
    bus.cmd_index = '0;
    bus.cmd_entry = {vpn2, asid, 51'($urandom)};
    check("p_ready", bus.cmd_ready, 1'b1);
    tick();
    if (hold) begin
      bus.cmd_op    = OP_R;
      bus.cmd_index = '0;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    cnt = 1;
    while (bus.resp_valid !== 1'b1 && cnt <= 40) begin
`ifndef TLB_PROBE_PARALLEL_EN
      check("p_busy_ready", bus.cmd_ready, 1'b0);
`endif
      tick();
      cnt++;
    end
    check("p_latency", cnt, lat);
    check("p_op", bus.resp_op, OP_P);
    check("p_miss", bus.resp_miss, (exp_idx < 0));
    check("p_index", bus.resp_index, (exp_idx < 0) ? 0 : exp_idx);
    check("p_resp_ready", bus.cmd_ready, 1'b1);
    got_idx = int'(bus.resp_index);
    if (hold) begin
      exp_r = m_ent[0];
      tick();
      bus.cmd_valid = 1'b0;
      check("held_valid", bus.resp_valid, 1'b1);
      check("held_op", bus.resp_op, OP_R);
      check("held_entry", bus.resp_entry, exp_r);
    end
  endtask

  initial begin
    int          got;
    logic [77:0] e;

    rst           = 1'b1;
    wired_i       = '0;
    wired_we      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_index = '0;
    bus.cmd_entry = '0;
    for (int i = 0; i < N; i++) m_ent[i] = '0;
    m_rand = N - 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_random", random_o, N - 1);
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_index", bus.resp_index, 0);
    check("rst_resp_entry", bus.resp_entry, 0);
    check("rst_entries", entries_o, 0);
    rst = 1'b0;

    // Step 1: idle with Wired = 0, so Random counts down and wraps.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_resp_valid", bus.resp_valid, 1'b0);
    end
    check("idle_entries", entries_o, 0);

    // Step 2: TLBWI, then TLBR of the same slot in the next cycle.
    e = mk(19'h12345, 8'h3A, 1'b0, 20'hABCDE, 1'b1);
    do_rw(OP_WI, 5, e);
    do_rw(OP_R, 5, '0);
    check("t2_entry", bus.resp_entry, e);
    check("t2_slot5", slot(5), e);

    // Step 3: duplicate VPN2. Entry 9 is global; entry 3 matches only once its ASID is 0x01.
    do_rw(OP_WI, 3, mk(19'h00777, 8'h02, 1'b0, 20'h00033, 1'b1));
    do_rw(OP_WI, 9, mk(19'h00777, 8'h55, 1'b1, 20'h00099, 1'b1));
    do_probe(19'h00777, 8'h01, 1'b0, got);
    check("t3_global_idx", got, 9);
    do_rw(OP_WI, 3, mk(19'h00777, 8'h01, 1'b0, 20'h00033, 1'b1));
    do_probe(19'h00777, 8'h01, 1'b0, got);
    check("t3_lowest_idx", got, 3);

    // Step 4: probe misses while a second command is held on the port.
    do_probe(19'h7FFFF, 8'h00, 1'b1, got);
    check("t4_miss_idx", got, 0);

    // Step 5: Wired = 12. TLBWR is issued while Random reads 13.
    wired_i  = IW'(12);
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    tick();
    tick();
    check("t5_random13", random_o, 13);
    e = mk(19'h04242, 8'h07, 1'b0, 20'h13131, 1'b1);
    do_rw(OP_WR, 0, e);
    check("t5_wr_index", bus.resp_index, 13);
    check("t5_slot13", slot(13), e);
    tick();
    tick();

    // Step 6: reset in SCAN cycle 4 aborts the probe.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_P;
    bus.cmd_entry = {19'h7FFFF, 59'b0};
    tick();
    bus.cmd_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    m_rand = N - 1;
    for (int i = 0; i < N; i++) m_ent[i] = '0;
    #1;
    check("t6_rst_random", random_o, N - 1);
    check("t6_rst_ready", bus.cmd_ready, 1'b1);
    check("t6_rst_entries", entries_o, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6_no_resp", bus.resp_valid, 1'b0);
      check("t6_ready", bus.cmd_ready, 1'b1);
    end
    wired_i = '0;

    // Randomized mix of commands and Wired writes.
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          wired_i  = IW'($urandom_range(0, N - 1));
          wired_we = 1'b1;
          tick();
          wired_we = 1'b0;
        end
        1, 2: do_probe(19'h00100 + 19'($urandom_range(0, 4)), 8'($urandom_range(0, 3)),
                       1'($urandom), got);
        3, 4, 5: do_rw(OP_R, $urandom_range(0, N - 1), '0);
        6, 7: do_rw(OP_WI, $urandom_range(0, N - 1), rnd_entry());
        default: do_rw(OP_WR, 0, rnd_entry());
      endcase
    end
    for (int i = 0; i < N; i++) check("final_slot", slot(i), m_ent[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlb_manager.md
Name: tlb_manager

Overview:
- Owns the TLB entry array and is its only writer; the lookup logic and CP0 consume the array read-only through entries_o.
- Executes CP0 TLB instructions TLBR, TLBWI, TLBWR and TLBP from the CP0/pipeline via a valid/ready command port, with a registered response pulse.
- Maintains the MIPS Random counter, bounded below by Wired.
- Default probe is a sequential scan state machine; a compile-time option gives a single-cycle parallel probe.

Parameters:
TLB_ENTRIES, 16, number of entries (power of 2, >= 2)
IDX_W, $clog2(TLB_ENTRIES), index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
cmd_index  in  IDX_W  CP0 Index, for TLBR/TLBWI
cmd_entry  in  78  {vpn2[18:0], asid[7:0], G, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1}; TLBP uses vpn2/asid only
wired_i  in  IDX_W  CP0 Wired value
wired_we  in  1  pulse: Wired was written
random_o  out  IDX_W  CP0 Random value
entries_o  out  78*TLB_ENTRIES  entry array, entry i at bits [78*i+:78]
resp_valid  out  1  one-cycle response pulse, no back-pressure
resp_op  out  2  op that produced the response
resp_index  out  IDX_W  TLBR/TLBWI: cmd_index; TLBWR: index written; TLBP: matching index or 0
resp_entry  out  78  TLBR: entry read; otherwise 0
resp_miss  out  1  TLBP only: 1 = no match

Behaviour:
- Reset values: all entries 0; random_o = TLB_ENTRIES-1; resp_* = 0; state IDLE; cmd_ready = 1.
- States: IDLE, SCAN. cmd_ready = (state == IDLE).
- TLBR accepted in cycle N:
  - resp_entry = entries[cmd_index], sampled in cycle N.
  - resp_valid high in N+1. State stays IDLE.
- TLBWI accepted in cycle N: entries[cmd_index] <= cmd_entry at the end of N; entries_o shows it in N+1; resp_valid high in N+1.
- TLBWR: same as TLBWI but the index is random_o as sampled in cycle N; resp_index returns that index.
- Back-to-back:
  - Non-probe ops can be accepted every cycle.
  - A TLBR of an index written in the previous cycle returns the new data.
- TLBP accepted in cycle N:
  - Latch key {vpn2, asid}; go to SCAN with scan_idx = 0.
  - In SCAN cycle N+1+k, compare entry k. Match = (vpn2 == key.vpn2) && (G || asid == key.asid).
  - First match (lowest index) ends the scan: state IDLE, resp_valid at N+2+k, resp_index = k, resp_miss = 0.
  - No match through k = TLB_ENTRIES-1: resp_valid at N+1+TLB_ENTRIES, resp_miss = 1, resp_index = 0.
  - cmd_ready is low throughout SCAN and high again in the response cycle.
- Random counter, evaluated every cycle with priority wired_we > wrap > decrement:
  - wired_we: random <= TLB_ENTRIES-1.
  - random <= wired_i: random <= TLB_ENTRIES-1 (wrap).
  - Otherwise: random <= random-1.
  - Random keeps counting during SCAN and on a TLBWR cycle.
  - With wired_i >= TLB_ENTRIES-1, random holds at TLB_ENTRIES-1.
- Duplicate-match entries: the lowest index wins, in both probe modes.
- rst asserted mid-SCAN: the scan is aborted, no response is produced, and all state returns to reset values immediately.
- cmd_op is ignored unless cmd_valid && cmd_ready.

Optional Feature:
TLB_PROBE_PARALLEL_EN
- Defined:
  - TLBP compares all entries combinationally in the accept cycle N, with a lowest-index priority encoder; resp_valid at N+1.
  - SCAN state is never entered and cmd_ready stays 1.
- Undefined: the sequential SCAN behaviour above.
- TLBR/TLBWI/TLBWR and Random behaviour are identical in both modes.

Test Plan:
1. Reset, then idle 20 cycles with wired_i=0 -> random_o sequence 15,14,...,1,0,15,...; entries_o all 0; resp_valid 0.
2. TLBWI index 5, entry vpn2=0x12345 asid=0x3A G=0 pfn0=0xABCDE v0=1; next cycle TLBR index 5 -> resp_entry equals the written value and entries_o slot 5 matches.
3. Preload entries 3 and 9 with the same vpn2=0x00777 (9 with G=1); TLBP vpn2=0x00777 asid=0x01 -> resp_index=9 (only 9 matches via G); set 3's asid=0x01 and repeat -> resp_index=3. Sequential latency N+5 for index 3; with TLB_PROBE_PARALLEL_EN, N+1.
4. TLBP of an absent vpn2 -> resp_miss=1, resp_index=0, resp_valid at N+17; cmd_valid held high during the probe is not accepted until the response cycle.
5. wired_i=12, pulse wired_we -> random 15,14,13,12,15,...; TLBWR while random=13 -> entry 13 written, resp_index=13.
6. Assert rst during SCAN cycle 4 -> no resp_valid, entries 0, random 15, cmd_ready 1 after rst deasserts.
